qea_host_sequencer: RTL and testbench

- Autonomous host-side sequencer for the QEA core.
- Per job: streams gate-context words into the context RAM, initialises the state RAM to |0...0>, pulses start, waits for completion while counting cycles, then streams the final state vector out under backpressure.
- Replaces bench-driven loading with a synthesizable, PE_NUM-generic controller; sits between the host/DMA interface and QEA.

---
 rtl/qea_host_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_qea_host_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_host_sequencer.sv
// ----------------------------------------------------------------------------
// qea_host_sequencer
//
// Autonomous host-side job controller for the QEA core. For each job it:
//   1. streams i_ins_num gate-context words into the QEA context RAM,
//   2. initialises the state RAM to |0...0> (amplitude 1.0 on the
//      most-significant lane of word 0, everything else zero),
//   3. pulses o_qea_start and counts cycles until i_qea_complete,
//   4. reads the final state vector back and streams it out under
//      valid/ready backpressure, then pulses o_done.
//
// Optional build macro: QEA_SEQ_TIMEOUT_EN
//   Defined   : a run lasting TIMEOUT_CYC cycles without completion sets the
//               sticky o_error, pulses o_done and skips readback.
//   Undefined : the run waits indefinitely and o_error stays 0.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_job_start, i_qbit_num, i_ins_num job request and parameters (IDLE only)
//   i_ctx_valid/o_ctx_ready, i_ctx_data  context word input stream
//   o_ctx_en/o_ctx_wea/o_ctx_addr/o_ctx_dout  context RAM write port
//   o_state_ena/o_state_wea/o_state_addra/o_state_dina  state RAM port
//   o_qea_start, i_qea_complete        QEA run control
//   i_state_dout                       state RAM read data
//   o_rd_valid/i_rd_ready, o_rd_data, o_rd_last  readback output stream
//   o_busy, o_done, o_exec_cycles, o_error  job status
// ----------------------------------------------------------------------------
module qea_host_sequencer #(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = 32,
   parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int NUM_FRAC_BIT            = 30,
   parameter int RD_LATENCY              = 1,
   parameter int CYC_WIDTH               = 32,
   parameter int TIMEOUT_CYC             = 2 ** 24
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     i_job_start,
   input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]       i_ins_num,
   input  logic                                     i_ctx_valid,
   output logic                                     o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]       i_ctx_data,
   output logic                                     o_ctx_en,
   output logic                                     o_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]       o_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]       o_ctx_dout,
   output logic                                     o_state_ena,
   output logic                                     o_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]       o_state_dina,
   output logic                                     o_qea_start,
   input  logic                                     i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
   output logic                                     o_rd_valid,
   input  logic                                     i_rd_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]       o_rd_data,
   output logic                                     o_rd_last,
   output logic                                     o_busy,
   output logic                                     o_done,
   output logic [CYC_WIDTH-1:0]                     o_exec_cycles,
   output logic                                     o_error
);

   localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
   localparam int SAW   = STATE_ADDR_WIDTH;
   localparam int SW    = PE_NUM * STATE_DATA_WIDTH;
   localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [LAT_W-1:0]          LAT_LAST = LAT_W'(RD_LATENCY - 1);
   localparam logic [MAX_QBIT_WIDTH-1:0] PNW_Q    = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   // Real half of the top lane sits in the top DATA_WIDTH bits of the word.
   localparam logic [SW-1:0] INIT_WORD = SW'(1) << (SW - DATA_WIDTH + NUM_FRAC_BIT);
`ifdef QEA_SEQ_TIMEOUT_EN
   localparam logic [CYC_WIDTH-1:0] TIMEOUT_LIM = CYC_WIDTH'(TIMEOUT_CYC);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_CTX, S_INIT_ST, S_START, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT
   } state_t;

   state_t                 state_q, state_d;
   logic [CAW-1:0]         ctx_idx_q, ctx_idx_d;
   logic [CAW-1:0]         ins_q, ins_d;
   logic [SAW-1:0]         last_q, last_d;
   logic [SAW-1:0]         st_idx_q, st_idx_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [CYC_WIDTH-1:0]   cyc_q, cyc_d, cyc_inc;
   logic [CYC_WIDTH-1:0]   exec_q, exec_d;
   logic                   err_q, err_d;
   logic                   done_q, done_d;
   logic [SW-1:0]          rd_data_q, rd_data_d;
   logic                   ctx_en_q, ctx_en_d;
   logic [CAW-1:0]         ctx_addr_q, ctx_addr_d;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_dout_q, ctx_dout_d;

   // Last state-word index for the requested qubit count. The shift is done
   // one bit wider than the address so a full 2**SAW depth (or more) yields
   // all-ones after the decrement instead of wrapping to zero.
   logic [MAX_QBIT_WIDTH-1:0] depth_sh;
   logic [SAW:0]              depth_m1;
   always_comb begin
      depth_sh = (i_qbit_num < PNW_Q) ? '0 : (i_qbit_num - PNW_Q);
      depth_m1 = ({{SAW{1'b0}}, 1'b1} << depth_sh) - 1'b1;
   end

   // Saturating run-cycle count including the current cycle.
   assign cyc_inc = (&cyc_q) ? cyc_q : (cyc_q + 1'b1);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      ctx_idx_d     = ctx_idx_q;
      ins_d         = ins_q;
      last_d        = last_q;
      st_idx_d      = st_idx_q;
      lat_d         = lat_q;
      cyc_d         = cyc_q;
      exec_d        = exec_q;
      err_d         = err_q;
      done_d        = 1'b0;
      rd_data_d     = rd_data_q;
      ctx_en_d      = 1'b0;
      ctx_addr_d    = ctx_addr_q;
      ctx_dout_d    = ctx_dout_q;
      o_ctx_ready   = 1'b0;
      o_state_ena   = 1'b0;
      o_state_wea   = 1'b0;
      o_state_addra = '0;
      o_state_dina  = '0;
      o_qea_start   = 1'b0;
      o_rd_valid    = 1'b0;
      o_rd_last     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_job_start) begin
               ins_d     = i_ins_num;
               last_d    = depth_m1[SAW-1:0];
               err_d     = 1'b0;
               ctx_idx_d = '0;
               st_idx_d  = '0;
               state_d   = (i_ins_num == '0) ? S_INIT_ST : S_LOAD_CTX;
            end
         end
         S_LOAD_CTX: begin
            o_ctx_ready = 1'b1;
            if (i_ctx_valid) begin
               ctx_en_d   = 1'b1;
               ctx_addr_d = ctx_idx_q;
               ctx_dout_d = i_ctx_data;
               if (ctx_idx_q == ins_q - CAW'(1)) begin
                  state_d = S_INIT_ST;
               end else begin
                  ctx_idx_d = ctx_idx_q + CAW'(1);
               end
            end
         end
         S_INIT_ST: begin
            o_state_ena   = 1'b1;
            o_state_wea   = 1'b1;
            o_state_addra = st_idx_q;
            o_state_dina  = (st_idx_q == '0) ? INIT_WORD : '0;
            if (st_idx_q == last_q) begin
               st_idx_d = '0;
               state_d  = S_START;
            end else begin
               st_idx_d = st_idx_q + SAW'(1);
            end
         end
         S_START: begin
            o_qea_start = 1'b1;
            cyc_d       = '0;
            state_d     = S_RUN;
         end
         S_RUN: begin
            cyc_d = cyc_inc;
            if (i_qea_complete) begin
               exec_d  = cyc_inc;
               state_d = S_RD_ADDR;
            end
`ifdef QEA_SEQ_TIMEOUT_EN
            else if (cyc_inc >= TIMEOUT_LIM) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
`endif
         end
         S_RD_ADDR: begin
            o_state_ena   = 1'b1;
            o_state_addra = st_idx_q;
            lat_d         = '0;
            state_d       = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (lat_q == LAT_LAST) begin
               rd_data_d = i_state_dout;
               state_d   = S_RD_OUT;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_RD_OUT: begin
            o_rd_valid = 1'b1;
            o_rd_last  = (st_idx_q == last_q);
            if (i_rd_ready) begin
               if (st_idx_q == last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  st_idx_d = st_idx_q + SAW'(1);
                  state_d  = S_RD_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ctx_idx_q  <= '0;
         ins_q      <= '0;
         last_q     <= '0;
         st_idx_q   <= '0;
         lat_q      <= '0;
         cyc_q      <= '0;
         exec_q     <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         ctx_en_q   <= 1'b0;
         ctx_addr_q <= '0;
         ctx_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         ctx_idx_q  <= ctx_idx_d;
         ins_q      <= ins_d;
         last_q     <= last_d;
         st_idx_q   <= st_idx_d;
         lat_q      <= lat_d;
         cyc_q      <= cyc_d;
         exec_q     <= exec_d;
         err_q      <= err_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
         ctx_en_q   <= ctx_en_d;
         ctx_addr_q <= ctx_addr_d;
         ctx_dout_q <= ctx_dout_d;
      end
   end

   assign o_ctx_en      = ctx_en_q;
   assign o_ctx_wea     = ctx_en_q;
   assign o_ctx_addr    = ctx_addr_q;
   assign o_ctx_dout    = ctx_dout_q;
   assign o_rd_data     = rd_data_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_done        = done_q;
   assign o_exec_cycles = exec_q;
   // Without the timeout feature err_q is only ever cleared, so this is 0.
   assign o_error       = err_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// ----------------------------------------------------------------------------
// tb_qea_host_sequencer
//
// Self-checking bench for qea_host_sequencer. Context words and readback
// words are pushed to scoreboard queues as they are offered / produced by the
// bench's QEA model, and popped when the DUT writes or streams them out.
// ----------------------------------------------------------------------------
module tb_qea_host_sequencer;

   localparam int SW  = 256;
   localparam int TMO = 100;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            i_job_start = 1'b0;
   logic [5:0]      i_qbit_num = '0;
   logic [15:0]     i_ins_num = '0;
   logic            i_ctx_valid = 1'b0;
   logic            o_ctx_ready;
   logic [63:0]     i_ctx_data = '0;
   logic            o_ctx_en, o_ctx_wea;
   logic [15:0]     o_ctx_addr;
   logic [63:0]     o_ctx_dout;
   logic            o_state_ena, o_state_wea;
   logic [15:0]     o_state_addra;
   logic [SW-1:0]   o_state_dina;
   logic            o_qea_start;
   logic            i_qea_complete = 1'b0;
   logic [SW-1:0]   i_state_dout;
   logic            o_rd_valid;
   logic            i_rd_ready = 1'b0;
   logic [SW-1:0]   o_rd_data;
   logic            o_rd_last;
   logic            o_busy, o_done;
   logic [31:0]     o_exec_cycles;
   logic            o_error;

   always #5 clk = ~clk;

   qea_host_sequencer #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_job_start(i_job_start), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
      .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
      .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr),
      .o_ctx_dout(o_ctx_dout),
      .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
      .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
      .o_qea_start(o_qea_start), .i_qea_complete(i_qea_complete),
      .i_state_dout(i_state_dout),
      .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
      .o_rd_last(o_rd_last),
      .o_busy(o_busy), .o_done(o_done), .o_exec_cycles(o_exec_cycles),
      .o_error(o_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboards and per-job bookkeeping
   logic [319:0] ctx_q[$];
   logic [319:0] rd_q[$];
   int  exp_depth = 1;
   int  ctx_acc, ctx_wr, st_wr, starts, dones, rd_cnt;
   int  cyc = 0;
   int  first_ctx, last_ctx, start_cyc, err_cyc;
   bit  ctx_seen, err_seen;
   bit  mon_en = 1'b0;
   int  ctx_mode = 2;   // 0: always valid, 1: toggle, 2: idle
   bit  rd_rand = 1'b0;
   int  qea_lat = 0;    // 0: QEA never completes

   logic [SW-1:0] init_word;
   logic [SW-1:0] res_mem [0:1023];
   logic [SW-1:0] rdata = '0;

   // State RAM read port of the QEA model, one cycle latency.
   always @(posedge clk) begin
      if (o_state_ena && !o_state_wea) rdata <= res_mem[o_state_addra[9:0]];
   end
   assign i_state_dout = rdata;

   // Input drivers, updated just after each rising edge.
   initial begin : drivers
      forever begin
         @(posedge clk);
         #1;
         i_rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         case (ctx_mode)
            0:       i_ctx_valid = 1'b1;
            1:       i_ctx_valid = ~i_ctx_valid;
            default: i_ctx_valid = 1'b0;
         endcase
         i_ctx_data = {$urandom, $urandom};
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin : monitor
      logic [SW-1:0] ew;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) begin
            if (o_ctx_en) begin
               ctx_wr++;
               if (!ctx_seen) first_ctx = cyc;
               ctx_seen = 1'b1;
               last_ctx = cyc;
               if (ctx_q.size() == 0) check("ctx_spurious", 1, 0);
               else check("ctx_write", {o_ctx_wea, o_ctx_addr, o_ctx_dout}, ctx_q.pop_front());
            end
            if (i_ctx_valid && o_ctx_ready) begin
               ctx_q.push_back({1'b1, 16'(ctx_acc), i_ctx_data});
               ctx_acc++;
            end
            if (o_state_ena && o_state_wea) begin
               ew = (st_wr == 0) ? init_word : {SW{1'b0}};
               check("st_init", {o_state_addra, o_state_dina}, {16'(st_wr), ew});
               st_wr++;
            end
            if (o_qea_start) begin
               starts++;
               start_cyc = cyc;
            end
            if (o_done) dones++;
            if (o_error && !err_seen) begin
               err_seen = 1'b1;
               err_cyc  = cyc;
            end
            if (o_rd_valid) begin
               if (rd_q.size() == 0) check("rd_spurious", 1, 0);
               else begin
                  check("rd_word", {o_rd_last, o_rd_data}, rd_q[0]);
                  if (i_rd_ready) begin
                     void'(rd_q.pop_front());
                     rd_cnt++;
                  end
               end
            end
         end
      end
   end

   // QEA model: on start, produce a random final state, then raise complete
   // qea_lat cycles after the start pulse cycle.
   initial begin : qea_model
      logic [SW-1:0] w;
      forever begin
         @(negedge clk);
         if (o_qea_start && qea_lat > 0) begin
            for (int a = 0; a < exp_depth; a++) begin
               for (int l = 0; l < SW / 32; l++) w[l*32 +: 32] = $urandom;
               res_mem[a] = w;
               rd_q.push_back({63'b0, 1'(a == exp_depth - 1), w});
            end
            repeat (qea_lat) @(posedge clk);
            #1 i_qea_complete = 1'b1;
            for (int k = 0; k < 20000; k++) begin
               @(negedge clk);
               if (o_rd_valid || !o_busy) break;
            end
            i_qea_complete = 1'b0;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, {o_busy, o_done, o_error, o_ctx_ready, o_ctx_en, o_ctx_wea,
                            o_state_ena, o_state_wea, o_qea_start, o_rd_valid, o_rd_last}, '0);
      check({tag, "_bus"}, {o_ctx_addr, o_state_addra, o_exec_cycles, o_ctx_dout}, '0);
      check({tag, "_dina"}, o_state_dina, '0);
      check({tag, "_rdata"}, o_rd_data, '0);
   endtask

   task automatic clear_job(input int qbit);
      exp_depth = (qbit < 2) ? 1 : (1 << (qbit - 2));
      ctx_acc = 0; ctx_wr = 0; st_wr = 0; starts = 0; dones = 0; rd_cnt = 0;
      ctx_seen = 1'b0; err_seen = 1'b0;
   endtask

   task automatic pulse_start(input int qbit, input int ins);
      @(posedge clk); #1;
      i_job_start = 1'b1;
      i_qbit_num  = 6'(qbit);
      i_ins_num   = 16'(ins);
      @(posedge clk); #1;
      i_job_start = 1'b0;
   endtask

   task automatic run_job(input int qbit, input int ins, input int cmode, input bit rrand,
                          input int lat, input bit poke, input string name);
      bit got_done;
      bit tmo;
      int budget;
      tmo = (lat == 0);
      clear_job(qbit);
      ctx_mode = cmode;
      rd_rand  = rrand;
      qea_lat  = lat;
      pulse_start(qbit, ins);
      if (poke) begin
         // A second request while busy must be ignored.
         repeat (4) @(posedge clk);
         #1 i_job_start = 1'b1; i_qbit_num = 6'd12; i_ins_num = 16'd3;
         @(posedge clk); #1 i_job_start = 1'b0;
      end
      budget   = ins * 3 + exp_depth * 12 + lat + (tmo ? TMO : 0) + 300;
      got_done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (dones > 0) begin
            got_done = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, got_done, 1);
      repeat (3) @(negedge clk);
      ctx_mode = 2;
      check({name, "_ctx_writes"}, ctx_wr, ins);
      check({name, "_st_writes"}, st_wr, exp_depth);
      check({name, "_start_pulses"}, starts, 1);
      check({name, "_done_pulses"}, dones, 1);
      check({name, "_rd_words"}, rd_cnt, tmo ? 0 : exp_depth);
      check({name, "_error"}, o_error, tmo);
      check({name, "_busy"}, o_busy, 0);
      check({name, "_queues"}, ctx_q.size() + rd_q.size(), 0);
      if (!tmo) check({name, "_exec_cycles"}, o_exec_cycles, lat);
      if (cmode == 0 && ins > 0) check({name, "_ctx_span"}, last_ctx - first_ctx + 1, ins);
   endtask

   initial begin : main
      bit in_init;
      init_word = '0;
      init_word[SW-1 -: 32] = 32'h4000_0000;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 check_idle_outputs("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      run_job(10, 319, 0, 1'b0, 500, 1'b0, "big");
      run_job(4, 8, 1, 1'b1, 37, 1'b1, "toggle_rand");
      run_job(1, 0, 0, 1'b1, 3, 1'b0, "q1_noctx");
      run_job(2, 1, 1, 1'b1, 1, 1'b0, "q2_one");

      // Asynchronous reset while the state RAM is being initialised.
      clear_job(10);
      ctx_mode = 0;
      rd_rand  = 1'b0;
      qea_lat  = 500;
      pulse_start(10, 4);
      in_init = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (st_wr >= 10) begin
            in_init = 1'b1;
            break;
         end
      end
      check("rst_reached_init", in_init, 1);
      @(posedge clk);
      #3 mon_en = 1'b0;
      rst_n = 1'b0;
      #1 check_idle_outputs("async_rst");
      repeat (2) @(posedge clk);
      ctx_q.delete();
      rd_q.delete();
      ctx_mode = 2;
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_job(6, 5, 0, 1'b1, 20, 1'b0, "after_rst");

`ifdef QEA_SEQ_TIMEOUT_EN
      run_job(4, 2, 0, 1'b0, 0, 1'b0, "timeout");
      check("timeout_err_seen", err_seen, 1);
      check("timeout_err_cycle", err_cyc - start_cyc, TMO + 1);
      run_job(3, 1, 0, 1'b0, 9, 1'b0, "post_timeout");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
